load_store_unit: RTL

- Sits directly upstream of the core's word-addressed data memory, between the execute/memory pipeline stage and the memory.
- Accepts byte, halfword and word load/store requests carrying a byte address, over a valid/ready handshake.
- Converts each request into word-indexed memory accesses. Sub-word stores use read-modify-write.
- Returns aligned, sign- or zero-extended load data, or an error, over a second valid/ready handshake.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_if.sv | 42 ++++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the all-zero data word.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/lsu_if.sv
// Bus bundles around the load/store unit: core-side request/response
// handshake and the word-addressed data memory port.
interface lsu_core_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddress;
  logic [31:0] reqWriteData;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspReadData;
  logic        rspError;

  modport master (
    output reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData, rspReady,
    input  reqReady, rspValid, rspReadData, rspError
  );

  modport slave (
    input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData, rspReady,
    output reqReady, rspValid, rspReadData, rspError
  );
endinterface

interface lsu_mem_if;
  logic [31:0] memAddress;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  modport master (
    output memAddress, memWriteEnable, memWriteData,
    input  memReadData
  );

  modport slave (
    input  memAddress, memWriteEnable, memWriteData,
    output memReadData
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a byte/halfword from a memory
// word for loads, and merges store data into a word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] data_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merge_o  = data_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o = word_i;
        merge_o[{lane_i, 3'b000} +: 8] = data_i[7:0];
      end
      SIZE_HALF: begin
        load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o = word_i;
        merge_o[{lane_i[1], 4'b0000} +: 16] = data_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed byte/half/word requests into word
// accesses on the data memory, using read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1000
) (
  input  logic       clk,
  input  logic       rst,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  state_e      state_q;
  logic        write_q;
  logic        unsigned_q;
  size_e       size_q;
  logic [29:0] index_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rsp_data_q;
  logic        rsp_valid_q;
  logic        rsp_error_q;

  logic        req_error_d;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    case (size_e'(core.reqSize))
      SIZE_BYTE: req_error_d = 1'b0;
      SIZE_HALF: req_error_d = core.reqAddress[0];
      SIZE_WORD: req_error_d = |core.reqAddress[1:0];
      default:   req_error_d = 1'b1;
    endcase
    if ({2'b00, core.reqAddress[31:2]} >= MEM_DEPTH) req_error_d = 1'b1;
  end

  lsu_lane_align u_lane_align (
    .word_i     (mem.memReadData),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_i     (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  assign core.reqReady    = (state_q == ST_IDLE);
  assign core.rspValid    = rsp_valid_q;
  assign core.rspReadData = rsp_data_q;
  assign core.rspError    = rsp_error_q;

  // Memory strobes decode straight from state, so an async reset kills a write at once.
  always_comb begin
    mem.memAddress     = WORD_ZERO;
    mem.memWriteEnable = 1'b0;
    mem.memWriteData   = WORD_ZERO;
    case (state_q)
      ST_ACCESS: begin
        mem.memAddress = {2'b00, index_q};
        if (write_q && size_q == SIZE_WORD) begin
          mem.memWriteEnable = 1'b1;
          mem.memWriteData   = wdata_q;
        end
      end
      ST_WRITE: begin
        mem.memAddress     = {2'b00, index_q};
        mem.memWriteEnable = 1'b1;
        mem.memWriteData   = merge_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, under async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= SIZE_BYTE;
      index_q     <= '0;
      lane_q      <= '0;
      wdata_q     <= WORD_ZERO;
      merge_q     <= WORD_ZERO;
      rsp_data_q  <= WORD_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core.reqValid) begin
            write_q     <= core.reqWrite;
            unsigned_q  <= core.reqUnsigned;
            size_q      <= size_e'(core.reqSize);
            index_q     <= core.reqAddress[31:2];
            lane_q      <= core.reqAddress[1:0];
            wdata_q     <= core.reqWriteData;
            rsp_data_q  <= WORD_ZERO;
            rsp_error_q <= req_error_d;
            rsp_valid_q <= req_error_d;
            state_q     <= req_error_d ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!write_q) begin
            rsp_data_q  <= load_data;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (size_q == SIZE_WORD) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            merge_q <= merge_data;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (core.rspReady) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= WORD_ZERO;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
